ahb_lite_adc_max10_bus: RTL and testbench



---
 rtl/ahb_lite_adc_max10_bus.sv | 126 ++++++++++++
 tb/tb_ahb_lite_adc_max10_bus.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_adc_max10_bus.sv
// rtl/ahb_lite_adc_max10_bus.sv - AHB-Lite slave front end for the MAX10 ADC register core
//
// Purpose:
//   Turns AHB-Lite address/data-phase transfers into the register access port of
//   the ADC core. Legal word accesses complete with zero wait states. With
//   ADC_AHB_ERROR_EN defined, illegal accesses (HSIZE != word or HADDR[1:0] != 0)
//   get a two-cycle ERROR response and never reach the core.
//
// Configuration macro: ADC_AHB_ERROR_EN (undefined: HRESP tied 0, HREADYOUT tied 1)
//
// Ports:
//   CLK, RESETn                  clock, synchronous active-low reset
//   HSEL, HADDR, HTRANS, HSIZE   AHB-Lite address phase
//   HWRITE, HWDATA, HREADY       direction, write data (data phase), bus ready
//   HBURST, HPROT, HMASTLOCK     accepted, ignored
//   HRDATA, HREADYOUT, HRESP     AHB-Lite slave response
//   read_addr, read_data         core read port (read_data combinational from read_addr)
//   write_addr, write_data,
//   write_enable                 core write port, one-cycle strobe
module ahb_lite_adc_max10_bus #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  write_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  state_q, state_d;
  logic                    accept;
  logic                    illegal;
  logic [ADDR_WIDTH-1:0]   read_addr_q;
  logic [ADDR_WIDTH-1:0]   write_addr_q;
  logic                    write_en_q;
  logic                    read_sel_q;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, HBURST, HPROT, HMASTLOCK, HTRANS[0],
                           HADDR[31:ADDR_WIDTH+2], HADDR[1:0], HSIZE};

  // No address phase can complete while we are driving the first ERROR cycle.
  assign accept = HSEL & HREADY & HTRANS[1] & (state_q != S_ERR1);

`ifdef ADC_AHB_ERROR_EN
  logic hreadyout_q;
  logic hresp_q;
  assign illegal   = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00);
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
`else
  assign illegal   = 1'b0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (HREADY) begin
      if (accept && illegal)     state_d = S_ERR1;
      else if (accept && HWRITE) state_d = S_WRITE;
      else if (accept)           state_d = S_READ;
      else                       state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q      <= S_IDLE;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      write_en_q   <= 1'b0;
      read_sel_q   <= 1'b0;
`ifdef ADC_AHB_ERROR_EN
      hreadyout_q  <= 1'b1;
      hresp_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      write_en_q <= (state_d == S_WRITE);
      read_sel_q <= (state_d == S_READ);
`ifdef ADC_AHB_ERROR_EN
      hreadyout_q <= (state_d != S_ERR1);
      hresp_q     <= (state_d == S_ERR1) || (state_d == S_ERR2);
`endif
      if (accept) begin
        read_addr_q  <= HADDR[ADDR_WIDTH+1:2];
        write_addr_q <= HADDR[ADDR_WIDTH+1:2];
      end
    end
  end

  assign read_addr    = read_addr_q;
  assign write_addr   = write_addr_q;
  assign write_data   = HWDATA;
  // Reset is synchronous, so gate the strobe directly to drop a pending write
  // in the very cycle reset is asserted.
  assign write_enable = write_en_q & RESETn;
  assign HRDATA       = read_sel_q ? read_data : 32'h0;

endmodule

// File: tb/tb_ahb_lite_adc_max10_bus.sv
// tb/tb_ahb_lite_adc_max10_bus.sv - directed self-checking bench for ahb_lite_adc_max10_bus
module tb_ahb_lite_adc_max10_bus;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] core_mem [16];

  always #5 CLK = ~CLK;

  ahb_lite_adc_max10_bus #(.ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable)
  );

  // Simple register core model: combinational read, write at clock edge.
  assign read_data = core_mem[read_addr];
  always @(posedge CLK) begin
    if (write_enable) core_mem[write_addr] <= write_data;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    else
      checks_passed++;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
    HSIZE = 3'b010; HREADY = 1'b1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size; HREADY = 1'b1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    bus_idle();
    step(); step();
    if (write_enable !== 1'b0) begin checks_total++; $display("FAIL reset_we: got %0b expected 0", write_enable); end
    else begin checks_total++; checks_passed++; end
    check("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("reset_hresp",     {31'h0, HRESP},     32'h0);
    check("reset_hrdata",    HRDATA,             32'h0);
    check("reset_read_addr", {28'h0, read_addr}, 32'h0);
    check("reset_write_addr",{28'h0, write_addr},32'h0);
    RESETn = 1'b1;
    step();
  endtask

  task automatic test_write_read_b2b();
    addr_phase(1'b1, 32'h04, 3'b010);
    step();
    HWDATA = 32'h3FF;
    addr_phase(1'b0, 32'h04, 3'b010);
    #1;
    check("b2b_we",         {31'h0, write_enable}, 32'h1);
    check("b2b_write_addr", {28'h0, write_addr},   32'h1);
    check("b2b_write_data", write_data,            32'h3FF);
    check("b2b_wr_ready",   {31'h0, HREADYOUT},    32'h1);
    check("b2b_wr_resp",    {31'h0, HRESP},        32'h0);
    step();
    bus_idle();
    #1;
    check("b2b_rd_we",        {31'h0, write_enable}, 32'h0);
    check("b2b_read_addr",    {28'h0, read_addr},    32'h1);
    check("b2b_hrdata",       HRDATA,                32'h3FF);
    check("b2b_rd_ready",     {31'h0, HREADYOUT},    32'h1);
    check("b2b_rd_resp",      {31'h0, HRESP},        32'h0);
    step();
    check("b2b_idle_hrdata",  HRDATA,                32'h0);
  endtask

  task automatic test_idle_busy();
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h08; HREADY = 1'b1;
    step();
    check("idle_we",    {31'h0, write_enable}, 32'h0);
    check("idle_ready", {31'h0, HREADYOUT},    32'h1);
    HTRANS = 2'b01;
    step();
    check("busy_we",    {31'h0, write_enable}, 32'h0);
    HSEL = 1'b0; HTRANS = 2'b10;
    step();
    check("unsel_we",    {31'h0, write_enable}, 32'h0);
    check("unsel_ready", {31'h0, HREADYOUT},    32'h1);
    bus_idle();
    step();
  endtask

  task automatic test_foreign_stall();
    addr_phase(1'b1, 32'h08, 3'b010);
    HREADY = 1'b0;
    step();
    check("stall_we", {31'h0, write_enable}, 32'h0);
    HREADY = 1'b1;
    step();
    bus_idle();
    HWDATA = 32'h1234;
    #1;
    check("stall_late_we",    {31'h0, write_enable}, 32'h1);
    check("stall_write_addr", {28'h0, write_addr},   32'h2);
    step();
    check("stall_mem", core_mem[2], 32'h1234);
  endtask

  task automatic test_reset_mid_transfer();
    addr_phase(1'b1, 32'h0C, 3'b010);
    step();
    bus_idle();
    HWDATA = 32'hDEAD;
    RESETn = 1'b0;
    #1;
    check("rst_mid_we_now", {31'h0, write_enable}, 32'h0);
    step();
    check("rst_mid_we_after", {31'h0, write_enable}, 32'h0);
    check("rst_mid_read_addr",{28'h0, read_addr},    32'h0);
    check("rst_mid_hrdata",   HRDATA,                32'h0);
    check("rst_mid_ready",    {31'h0, HREADYOUT},    32'h1);
    check("rst_mid_mem",      core_mem[3],           32'h0);
    RESETn = 1'b1;
    step();
  endtask

  task automatic test_error_response();
    logic [31:0] bad_addr [2];
    logic [2:0]  bad_size [2];
    bad_addr[0] = 32'h06; bad_size[0] = 3'b010;
    bad_addr[1] = 32'h04; bad_size[1] = 3'b001;
    // Seed register 0 so the follow-up read has a distinctive value.
    addr_phase(1'b1, 32'h00, 3'b010);
    step();
    bus_idle();
    HWDATA = 32'hABCD;
    step();
    for (int i = 0; i < 2; i++) begin
      addr_phase(1'b1, bad_addr[i], bad_size[i]);
      step();
      HWDATA = 32'h55 + i;
`ifdef ADC_AHB_ERROR_EN
      HSEL = 1'b1; HTRANS = 2'b00; HREADY = 1'b0;
      #1;
      check("err1_ready", {31'h0, HREADYOUT},    32'h0);
      check("err1_resp",  {31'h0, HRESP},        32'h1);
      check("err1_we",    {31'h0, write_enable}, 32'h0);
      step();
      check("err2_ready", {31'h0, HREADYOUT},    32'h1);
      check("err2_resp",  {31'h0, HRESP},        32'h1);
      check("err2_we",    {31'h0, write_enable}, 32'h0);
      addr_phase(1'b0, 32'h00, 3'b010);
      step();
      check("err_mem_untouched", core_mem[1], 32'h3FF);
`else
      addr_phase(1'b0, 32'h00, 3'b010);
      #1;
      check("noerr_resp",       {31'h0, HRESP},        32'h0);
      check("noerr_we",         {31'h0, write_enable}, 32'h1);
      check("noerr_write_addr", {28'h0, write_addr},   32'h1);
      step();
      check("noerr_mem", core_mem[1], 32'h55 + i);
`endif
      bus_idle();
      #1;
      check("after_err_hrdata", HRDATA,             32'hABCD);
      check("after_err_resp",   {31'h0, HRESP},     32'h0);
      check("after_err_ready",  {31'h0, HREADYOUT}, 32'h1);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) core_mem[i] = 32'h0;
    HBURST = 3'b000; HPROT = 4'b0011; HMASTLOCK = 1'b0; HWDATA = 32'h0;
    RESETn = 1'b0;
    bus_idle();
    #1;
    test_reset();
    test_write_read_b2b();
    test_idle_busy();
    test_foreign_stall();
    test_reset_mid_transfer();
    test_error_response();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
